dmem_bus_bridge: RTL and testbench
==================================

# dmem_bus_bridge

Bridge between the core's single-cycle data-memory port and a variable-latency valid/ready memory bus. It sits directly downstream of the core's EX-stage store/address-generation logic. It issues one bus transaction per load or store and drives the core's global `stall_i` until the response returns. Load data is delivered on the core's MA-stage read port in the cycle the stall releases.

## Interface
Parameters:
- `XLEN`, 32, data/address width
- `XBYTES`, `XLEN/8`, write-strobe width

Ports (one clock; reset is asynchronous and active-high):
- `clk_i`  in  1  clock
- `rst_i`  in  1  asynchronous active-high reset
- `dmem_addr_i`  in  XLEN  core EX-stage byte address
- `dmem_rreq_i`  in  1  core load request (EX valid && load)
- `dmem_wvalid_i`  in  1  core store request
- `dmem_wdata_i`  in  XLEN  store data, already lane-replicated
- `dmem_wstrb_i`  in  XBYTES  store byte strobes
- `dmem_rdata_o`  out  XLEN  load data to core MA stage
- `stall_o`  out  1  to core `stall_i`
- `bus_req_valid_o`  out  1  bus request valid
- `bus_req_ready_i`  in  1  bus request ready
- `bus_req_we_o`  out  1  1 = write
- `bus_req_addr_o`  out  XLEN  word-aligned address (`addr & ~(XBYTES-1)`)
- `bus_req_wdata_o`  out  XLEN  write data
- `bus_req_wstrb_o`  out  XBYTES  strobes; 0 for reads
- `bus_rsp_valid_i`  in  1  response/ack valid (single-cycle pulse)
- `bus_rsp_rdata_i`  in  XLEN  read data, valid with `bus_rsp_valid_i`
- `stall_cnt_o`  out  32  count of cycles with `stall_o` high
- `err_o`  out  1  sticky: protocol violation seen

## Operation
- States: IDLE, REQ (request presented, waiting for ready), WAIT (request accepted, waiting for response).
- Accept condition: `(dmem_rreq_i || dmem_wvalid_i) && !stall_o && (state==IDLE || (state==WAIT && bus_rsp_valid_i))`.
- On accept: capture we (= `dmem_wvalid_i`), aligned address, wdata, and wstrb (forced to 0 for reads) into request registers; go to REQ.
- REQ: `bus_req_valid_o`=1 with fields held stable. On `bus_req_ready_i` → WAIT.
- WAIT: on `bus_rsp_valid_i`, complete the transaction. Go to REQ if a new accept occurs in that cycle, else IDLE.
- Simultaneous `dmem_rreq_i` and `dmem_wvalid_i`: treat as a write; set `err_o`.
- `stall_o = (state==REQ) || (state==WAIT && !bus_rsp_valid_i)`. This is combinational, so the core advances in the response cycle.
- `dmem_rdata_o = (state==WAIT && bus_rsp_valid_i) ? bus_rsp_rdata_i : rdata_q`.
  - `rdata_q` captures `bus_rsp_rdata_i` on every completion of a read.
  - Write completions do not update `rdata_q`.
  - Byte/half extraction remains in the core.
- `bus_rsp_valid_i` in IDLE or REQ: ignore it and set `err_o`.
- `stall_cnt_o` increments by 1 every cycle `stall_o`=1 and wraps at 2^32-1 → 0.

## Timing
- Reset (async, immediate on `rst_i` rise): state=IDLE, `bus_req_valid_o`=0, `stall_o`=0, `bus_req_*`=0, `rdata_q`=0, `dmem_rdata_o`=0, `stall_cnt_o`=0, `err_o`=0.
- Reset mid-transaction: the in-flight transaction is abandoned. After reset, responses are handled per the IDLE rule.
- Accept in cycle t → `bus_req_valid_o`=1 from t+1, and `stall_o`=1 at t+1.
- Best case: ready at t+1, response at t+2 → exactly 1 stall cycle (t+1). Load data is valid on `dmem_rdata_o` at t+2 with `stall_o`=0.
- General stall length: (cycles in REQ) + (cycles in WAIT before the response).
- The request whose response completes in cycle c may be followed by a new accept in the same cycle c. There are no bubble cycles between back-to-back memory ops.
- `bus_req_valid_o` never drops and request fields never change between assertion and ready.
- While stalled, core request inputs are ignored. The core holds them frozen.

## Test plan
- Single load: addr=0x103, rreq at t; ready at t+1; rsp at t+3 with rdata=0xDEADBEEF.
  - Required: `bus_req_addr_o`=0x100, wstrb=0, we=0.
  - Required: `stall_o` high t+1..t+2, low t+3.
  - Required: `dmem_rdata_o`=0xDEADBEEF at t+3 and held afterwards; `stall_cnt_o`=2.
- Store sb: addr=0x202, wstrb=0100, wdata=0x55555555; ready delayed 3 cycles; ack 1 cycle later.
  - Required: fields stable through REQ, we=1, addr=0x200.
  - Required: stall for 4 cycles; `rdata_q` unchanged.
- Back-to-back: load, then store presented in the load's response cycle.
  - Required: store accepted in that same cycle; `bus_req_valid_o` high the following cycle; no IDLE cycle between.
- Spurious `bus_rsp_valid_i` in IDLE → `err_o`=1 and sticky; state, `stall_o`, and `dmem_rdata_o` unchanged.
- Async reset asserted in WAIT (between clock edges) → `stall_o` and `bus_req_valid_o` fall immediately; after release, a new load completes normally.
- Counter wrap: preload/force `stall_cnt_o` to 0xFFFFFFFF, then 1 stall cycle → `stall_cnt_o`=0.

Source files
------------

// File: rtl/dmem_bus_if.sv
// ---------------------------------------------------------------------------
// dmem_bus_if
//   Valid/ready memory bus between the data-memory bridge (master) and the
//   memory subsystem (slave). The request channel uses a valid/ready
//   handshake. The response channel is a single-cycle valid pulse with read
//   data. It carries no ready signal because the bridge always accepts a
//   response.
//
//   Signals (named from the bridge's point of view):
//     bus_req_valid_o  request valid
//     bus_req_ready_i  request accepted by the memory
//     bus_req_we_o     1 = write, 0 = read
//     bus_req_addr_o   word-aligned byte address
//     bus_req_wdata_o  write data
//     bus_req_wstrb_o  byte write strobes (0 for reads)
//     bus_rsp_valid_i  response / write-ack pulse
//     bus_rsp_rdata_i  read data, qualified by bus_rsp_valid_i
// ---------------------------------------------------------------------------
interface dmem_bus_if #(
    parameter int XLEN = 32
);
    localparam int XBYTES = XLEN / 8;

    logic              bus_req_valid_o;
    logic              bus_req_ready_i;
    logic              bus_req_we_o;
    logic [XLEN-1:0]   bus_req_addr_o;
    logic [XLEN-1:0]   bus_req_wdata_o;
    logic [XBYTES-1:0] bus_req_wstrb_o;
    logic              bus_rsp_valid_i;
    logic [XLEN-1:0]   bus_rsp_rdata_i;

    modport master (
        output bus_req_valid_o,
        input  bus_req_ready_i,
        output bus_req_we_o,
        output bus_req_addr_o,
        output bus_req_wdata_o,
        output bus_req_wstrb_o,
        input  bus_rsp_valid_i,
        input  bus_rsp_rdata_i
    );

    modport slave (
        input  bus_req_valid_o,
        output bus_req_ready_i,
        input  bus_req_we_o,
        input  bus_req_addr_o,
        input  bus_req_wdata_o,
        input  bus_req_wstrb_o,
        output bus_rsp_valid_i,
        output bus_rsp_rdata_i
    );
endinterface

// File: rtl/dmem_bus_bridge.sv
// ---------------------------------------------------------------------------
// dmem_bus_bridge
//   Converts the core's single-cycle data-memory port into one transaction
//   per load or store on a variable-latency valid/ready bus. The core is
//   held with stall_o until the response arrives. Load data reaches the
//   core's MA stage in the same cycle that the stall releases.
//
//   Ports:
//     clk_i, rst_i    clock and asynchronous active-high reset
//     dmem_addr_i     EX-stage byte address
//     dmem_rreq_i     load request
//     dmem_wvalid_i   store request
//     dmem_wdata_i    store data (already lane-replicated)
//     dmem_wstrb_i    store byte strobes
//     dmem_rdata_o    load data to MA stage
//     stall_o         global core stall
//     bus             memory bus, master side (see dmem_bus_if)
//     stall_cnt_o     free-running count of stalled cycles (wraps)
//     err_o           sticky protocol-violation flag
// ---------------------------------------------------------------------------
module dmem_bus_bridge #(
    parameter int XLEN   = 32,
    parameter int XBYTES = XLEN / 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [XLEN-1:0]   dmem_addr_i,
    input  logic              dmem_rreq_i,
    input  logic              dmem_wvalid_i,
    input  logic [XLEN-1:0]   dmem_wdata_i,
    input  logic [XBYTES-1:0] dmem_wstrb_i,
    output logic [XLEN-1:0]   dmem_rdata_o,
    output logic              stall_o,
    dmem_bus_if.master        bus,
    output logic [31:0]       stall_cnt_o,
    output logic              err_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT
    } state_t;

    localparam logic [XLEN-1:0] ADDR_MASK = ~XLEN'(XBYTES - 1);

    state_t            state_q;
    logic              req_valid_q;
    logic              req_we_q;
    logic [XLEN-1:0]   req_addr_q;
    logic [XLEN-1:0]   req_wdata_q;
    logic [XBYTES-1:0] req_wstrb_q;
    logic [XLEN-1:0]   rdata_q;
    logic [31:0]       stall_cnt_q;
    logic              err_q;

    logic rsp_done;
    logic accept;

    // The response cycle is not a stall, so the core moves on in the same
    // cycle and may present its next memory op at once.
    assign rsp_done = (state_q == ST_WAIT) && bus.bus_rsp_valid_i;
    assign stall_o  = (state_q == ST_REQ) ||
                      ((state_q == ST_WAIT) && !bus.bus_rsp_valid_i);
    assign accept   = (dmem_rreq_i || dmem_wvalid_i) && !stall_o &&
                      ((state_q == ST_IDLE) || rsp_done);

    // Forward the response straight to the core in the completion cycle.
    // In all other cycles, hold the data from the most recent load.
    assign dmem_rdata_o = rsp_done ? bus.bus_rsp_rdata_i : rdata_q;

    assign bus.bus_req_valid_o = req_valid_q;
    assign bus.bus_req_we_o    = req_we_q;
    assign bus.bus_req_addr_o  = req_addr_q;
    assign bus.bus_req_wdata_o = req_wdata_q;
    assign bus.bus_req_wstrb_o = req_wstrb_q;
    assign stall_cnt_o         = stall_cnt_q;
    assign err_o               = err_q;

    // NOTE: every register below is assigned with <= so that all flops
    // sample the pre-edge values of their inputs, independent of statement
    // order inside the block.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            req_valid_q <= 1'b0;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_wstrb_q <= '0;
            rdata_q     <= '0;
            stall_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            if (stall_o) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end

            // A response with no request outstanding is a protocol
            // violation. It is otherwise ignored.
            if (bus.bus_rsp_valid_i && (state_q != ST_WAIT)) begin
                err_q <= 1'b1;
            end

            // A load and a store in the same cycle are illegal. The store
            // takes priority.
            if (accept && dmem_rreq_i && dmem_wvalid_i) begin
                err_q <= 1'b1;
            end

            // When a request is accepted, capture it. This also covers a
            // request that arrives back-to-back in a completion cycle.
            if (accept) begin
                req_valid_q <= 1'b1;
                req_we_q    <= dmem_wvalid_i;
                req_addr_q  <= dmem_addr_i & ADDR_MASK;
                req_wdata_q <= dmem_wdata_i;
                req_wstrb_q <= dmem_wvalid_i ? dmem_wstrb_i : '0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (bus.bus_req_ready_i) begin
                        req_valid_q <= 1'b0;
                        state_q     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.bus_rsp_valid_i) begin
                        if (!req_we_q) begin
                            rdata_q <= bus.bus_rsp_rdata_i;
                        end
                        state_q <= accept ? ST_REQ : ST_IDLE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    req_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// ---------------------------------------------------------------------------
// tb_dmem_bus_bridge
//   Self-checking bench for dmem_bus_bridge. The vector table is applied one
//   entry per clock cycle. After each edge, the inputs for the cycle are
//   driven at +1, and all outputs are compared at +2. The table is followed
//   by hand-written sequences for async reset, a spurious response and
//   stall-counter wrap.
// ---------------------------------------------------------------------------
module tb_dmem_bus_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] dmem_addr;
    logic        dmem_rreq;
    logic        dmem_wvalid;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_rdata;
    logic        stall;
    logic [31:0] stall_cnt;
    logic        err;

    int n_checks = 0;
    int n_err    = 0;

    dmem_bus_if #(.XLEN(32)) bus_if ();

    dmem_bus_bridge #(.XLEN(32), .XBYTES(4)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .dmem_addr_i   (dmem_addr),
        .dmem_rreq_i   (dmem_rreq),
        .dmem_wvalid_i (dmem_wvalid),
        .dmem_wdata_i  (dmem_wdata),
        .dmem_wstrb_i  (dmem_wstrb),
        .dmem_rdata_o  (dmem_rdata),
        .stall_o       (stall),
        .bus           (bus_if),
        .stall_cnt_o   (stall_cnt),
        .err_o         (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rreq;
        logic        wv;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        rdy;
        logic        rsp;
        logic [31:0] rsp_data;
        logic        e_stall;
        logic        e_valid;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_wstrb;
        logic [31:0] e_rdata;
        logic [31:0] e_cnt;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    task automatic av(input string nm, input logic rq, wv,
                      input logic [31:0] a, wd, input logic [3:0] ws,
                      input logic rdy, rsp, input logic [31:0] rd,
                      input logic es, ev, ewe, input logic [31:0] ea, ewd,
                      input logic [3:0] ews, input logic [31:0] erd, ecnt,
                      input logic eerr);
        vec_t v;
        v.name = nm; v.rreq = rq; v.wv = wv; v.addr = a; v.wdata = wd;
        v.wstrb = ws; v.rdy = rdy; v.rsp = rsp; v.rsp_data = rd;
        v.e_stall = es; v.e_valid = ev; v.e_we = ewe; v.e_addr = ea;
        v.e_wdata = ewd; v.e_wstrb = ews; v.e_rdata = erd; v.e_cnt = ecnt;
        v.e_err = eerr;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input logic [31:0] act, exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // Wait for the next edge, then drive the inputs for the new cycle.
    // The task returns with the outputs settled and ready to compare.
    task automatic drive(input logic rq, wv, input logic [31:0] a, wd,
                         input logic [3:0] ws, input logic rdy, rsp,
                         input logic [31:0] rd);
        @(posedge clk);
        #1;
        dmem_rreq = rq; dmem_wvalid = wv; dmem_addr = a;
        dmem_wdata = wd; dmem_wstrb = ws;
        bus_if.bus_req_ready_i = rdy;
        bus_if.bus_rsp_valid_i = rsp;
        bus_if.bus_rsp_rdata_i = rd;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1);
    end

    initial begin
        //  name     rq wv addr     wdata        ws    rdy rsp rsp_data      st vl we e_addr   e_wdata      e_ws  e_rdata       e_cnt e_err
        av("ld_t0",  1, 0, 'h103, 'h0,         4'hF, 0, 0, 'h0,          0, 0, 0, 'h0,    'h0,         4'h0, 'h0,          0,  0);
        av("ld_t1",  1, 0, 'h103, 'h0,         4'hF, 1, 0, 'h0,          1, 1, 0, 'h100,  'h0,         4'h0, 'h0,          0,  0);
        av("ld_t2",  1, 0, 'h103, 'h0,         4'hF, 0, 0, 'h0,          1, 0, 0, 'h0,    'h0,         4'h0, 'h0,          1,  0);
        av("ld_t3",  0, 0, 'h0,   'h0,         4'h0, 0, 1, 'hDEADBEEF,   0, 0, 0, 'h0,    'h0,         4'h0, 'hDEADBEEF,   2,  0);
        av("ld_t4",  0, 0, 'h0,   'h0,         4'h0, 0, 0, 'h0,          0, 0, 0, 'h0,    'h0,         4'h0, 'hDEADBEEF,   2,  0);
        av("sb_t0",  0, 1, 'h202, 'h55555555,  4'h4, 0, 0, 'h0,          0, 0, 0, 'h0,    'h0,         4'h0, 'hDEADBEEF,   2,  0);
        av("sb_t1",  0, 1, 'h202, 'h55555555,  4'h4, 0, 0, 'h0,          1, 1, 1, 'h200,  'h55555555,  4'h4, 'hDEADBEEF,   2,  0);
        av("sb_t2",  0, 1, 'h202, 'h55555555,  4'h4, 0, 0, 'h0,          1, 1, 1, 'h200,  'h55555555,  4'h4, 'hDEADBEEF,   3,  0);
        av("sb_t3",  0, 1, 'h202, 'h55555555,  4'h4, 0, 0, 'h0,          1, 1, 1, 'h200,  'h55555555,  4'h4, 'hDEADBEEF,   4,  0);
        av("sb_t4",  0, 1, 'h202, 'h55555555,  4'h4, 1, 0, 'h0,          1, 1, 1, 'h200,  'h55555555,  4'h4, 'hDEADBEEF,   5,  0);
        av("sb_t5",  0, 0, 'h0,   'h0,         4'h0, 0, 1, 'h12345678,   0, 0, 0, 'h0,    'h0,         4'h0, 'h12345678,   6,  0);
        av("sb_t6",  0, 0, 'h0,   'h0,         4'h0, 0, 0, 'h0,          0, 0, 0, 'h0,    'h0,         4'h0, 'hDEADBEEF,   6,  0);
        av("bb_t0",  1, 0, 'h10,  'h0,         4'h0, 0, 0, 'h0,          0, 0, 0, 'h0,    'h0,         4'h0, 'hDEADBEEF,   6,  0);
        av("bb_t1",  1, 0, 'h10,  'h0,         4'h0, 1, 0, 'h0,          1, 1, 0, 'h10,   'h0,         4'h0, 'hDEADBEEF,   6,  0);
        av("bb_t2",  1, 0, 'h10,  'h0,         4'h0, 0, 0, 'h0,          1, 0, 0, 'h0,    'h0,         4'h0, 'hDEADBEEF,   7,  0);
        av("bb_t3",  0, 1, 'h24,  'hA5A5A5A5,  4'hF, 0, 1, 'hCAFEF00D,   0, 0, 0, 'h0,    'h0,         4'h0, 'hCAFEF00D,   8,  0);
        av("bb_t4",  0, 1, 'h24,  'hA5A5A5A5,  4'hF, 1, 0, 'h0,          1, 1, 1, 'h24,   'hA5A5A5A5,  4'hF, 'hCAFEF00D,   8,  0);
        av("bb_t5",  0, 1, 'h24,  'hA5A5A5A5,  4'hF, 0, 0, 'h0,          1, 0, 0, 'h0,    'h0,         4'h0, 'hCAFEF00D,   9,  0);
        av("bb_t6",  0, 0, 'h0,   'h0,         4'h0, 0, 1, 'h0,          0, 0, 0, 'h0,    'h0,         4'h0, 'h0,          10, 0);
        av("bb_t7",  0, 0, 'h0,   'h0,         4'h0, 0, 0, 'h0,          0, 0, 0, 'h0,    'h0,         4'h0, 'hCAFEF00D,   10, 0);
        av("rw_t0",  1, 1, 'h31,  'h11111111,  4'hF, 0, 0, 'h0,          0, 0, 0, 'h0,    'h0,         4'h0, 'hCAFEF00D,   10, 0);
        av("rw_t1",  1, 1, 'h31,  'h11111111,  4'hF, 1, 0, 'h0,          1, 1, 1, 'h30,   'h11111111,  4'hF, 'hCAFEF00D,   10, 1);
        av("rw_t2",  0, 0, 'h0,   'h0,         4'h0, 0, 1, 'h77,         0, 0, 0, 'h0,    'h0,         4'h0, 'h77,         11, 1);
        av("rw_t3",  0, 0, 'h0,   'h0,         4'h0, 0, 0, 'h0,          0, 0, 0, 'h0,    'h0,         4'h0, 'hCAFEF00D,   11, 1);

        rst = 1'b1;
        dmem_rreq = 0; dmem_wvalid = 0; dmem_addr = 0; dmem_wdata = 0; dmem_wstrb = 0;
        bus_if.bus_req_ready_i = 0; bus_if.bus_rsp_valid_i = 0; bus_if.bus_rsp_rdata_i = 0;
        #3;
        check("rst_stall", 32'(stall), 0);
        check("rst_valid", 32'(bus_if.bus_req_valid_o), 0);
        check("rst_addr",  bus_if.bus_req_addr_o, 0);
        check("rst_rdata", dmem_rdata, 0);
        check("rst_cnt",   stall_cnt, 0);
        check("rst_err",   32'(err), 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].rreq, vecs[i].wv, vecs[i].addr, vecs[i].wdata,
                  vecs[i].wstrb, vecs[i].rdy, vecs[i].rsp, vecs[i].rsp_data);
            check({vecs[i].name, ".stall"}, 32'(stall), 32'(vecs[i].e_stall));
            check({vecs[i].name, ".valid"}, 32'(bus_if.bus_req_valid_o), 32'(vecs[i].e_valid));
            check({vecs[i].name, ".rdata"}, dmem_rdata, vecs[i].e_rdata);
            check({vecs[i].name, ".cnt"},   stall_cnt, vecs[i].e_cnt);
            check({vecs[i].name, ".err"},   32'(err), 32'(vecs[i].e_err));
            if (vecs[i].e_valid) begin
                check({vecs[i].name, ".we"},    32'(bus_if.bus_req_we_o), 32'(vecs[i].e_we));
                check({vecs[i].name, ".addr"},  bus_if.bus_req_addr_o, vecs[i].e_addr);
                check({vecs[i].name, ".wdata"}, bus_if.bus_req_wdata_o, vecs[i].e_wdata);
                check({vecs[i].name, ".wstrb"}, 32'(bus_if.bus_req_wstrb_o), 32'(vecs[i].e_wstrb));
            end
        end

        // Async reset between edges while a load is in WAIT.
        drive(1, 0, 'h40, 0, 0, 0, 0, 0);
        drive(1, 0, 'h40, 0, 0, 1, 0, 0);
        drive(1, 0, 'h40, 0, 0, 0, 0, 0);
        check("arst_pre_stall", 32'(stall), 1);
        rst = 1'b1;
        #1;
        check("arst_stall", 32'(stall), 0);
        check("arst_valid", 32'(bus_if.bus_req_valid_o), 0);
        check("arst_cnt",   stall_cnt, 0);
        check("arst_err",   32'(err), 0);
        check("arst_rdata", dmem_rdata, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        dmem_rreq = 0;
        drive(1, 0, 'h44, 0, 0, 0, 0, 0);
        check("post_t0_stall", 32'(stall), 0);
        drive(1, 0, 'h44, 0, 0, 1, 0, 0);
        check("post_t1_stall", 32'(stall), 1);
        check("post_t1_addr",  bus_if.bus_req_addr_o, 'h44);
        drive(0, 0, 0, 0, 0, 0, 1, 'hBEEF0001);
        check("post_t2_stall", 32'(stall), 0);
        check("post_t2_rdata", dmem_rdata, 'hBEEF0001);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check("post_t3_rdata", dmem_rdata, 'hBEEF0001);
        check("post_t3_cnt",   stall_cnt, 1);
        check("post_t3_err",   32'(err), 0);

        // Spurious response in IDLE.
        drive(0, 0, 0, 0, 0, 0, 1, 'h99999999);
        check("spur_t0_stall", 32'(stall), 0);
        check("spur_t0_rdata", dmem_rdata, 'hBEEF0001);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check("spur_t1_err",   32'(err), 1);
        check("spur_t1_stall", 32'(stall), 0);
        check("spur_t1_valid", 32'(bus_if.bus_req_valid_o), 0);
        check("spur_t1_rdata", dmem_rdata, 'hBEEF0001);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check("spur_t2_err",   32'(err), 1);

        // Stall counter wrap.
        force dut.stall_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cnt_q;
        drive(1, 0, 'h50, 0, 0, 0, 0, 0);
        check("wrap_t0_cnt", stall_cnt, 32'hFFFF_FFFF);
        drive(1, 0, 'h50, 0, 0, 1, 0, 0);
        check("wrap_t1_stall", 32'(stall), 1);
        drive(0, 0, 0, 0, 0, 0, 1, 'h1234);
        check("wrap_t2_cnt", stall_cnt, 0);
        check("wrap_t2_rdata", dmem_rdata, 'h1234);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check("wrap_t3_cnt", stall_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
